alu_dispatch: RTL and testbench

Upstream feeder for the ALU sequential datapath. Buffers operand pairs from a producer in a small FIFO, launches one ALU operation at a time via the ALU start/finished handshake, and holds each result pair for a downstream consumer under valid/ready. Serialises an arbitrary operand stream onto the single-operation ALU without the producer tracking ALU busy state.

---
 rtl/alu_dispatch_if.sv | 37 +++
 rtl/alu_dispatch.sv | 150 +++++++++++++++
 tb/tb_alu_dispatch.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_dispatch_if.sv
// Signal bundle between alu_dispatch and its producer, ALU and consumer.
// master = the dispatcher's view; slave = the surrounding environment.
interface alu_dispatch_if #(
  parameter int N     = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_A;
  logic [N-1:0]  in_B;
  logic [CW-1:0] count;

  logic          alu_start;
  logic [N-1:0]  alu_A;
  logic [N-1:0]  alu_B;
  logic          alu_finished;
  logic [N-1:0]  alu_Y;
  logic [N-1:0]  alu_X;

  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_Y;
  logic [N-1:0]  out_X;
  logic          out_error;

  modport master (
    input  in_valid, in_A, in_B, alu_finished, alu_Y, alu_X, out_ready,
    output in_ready, count, alu_start, alu_A, alu_B, out_valid, out_Y, out_X, out_error
  );

  modport slave (
    output in_valid, in_A, in_B, alu_finished, alu_Y, alu_X, out_ready,
    input  in_ready, count, alu_start, alu_A, alu_B, out_valid, out_Y, out_X, out_error
  );
endinterface

// File: rtl/alu_dispatch.sv
// Operand FIFO + single-op launcher for the sequential ALU, result held under valid/ready.
// Optional WAIT-state watchdog enabled by defining ALU_DISPATCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair in the FIFO
// ISSUE | alu_start pulse, operands already registered
// WAIT  | ALU busy, waiting for alu_finished (or timeout)
// HOLD  | result presented to consumer until out_ready
module alu_dispatch #(
  parameter int N       = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clock,
  input  logic           reset,
  alu_dispatch_if.master io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("alu_dispatch: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t         state;
  state_t         state_nx;
  logic [2*N-1:0] mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  cnt;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           fin_take;
  logic           tmo_take;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   y_q;
  logic [N-1:0]   x_q;
  logic           start_o;
  logic           valid_o;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign push     = io.in_valid && io.in_ready;
  assign pop      = !empty && ((state == IDLE) || (state == HOLD && io.out_ready));
  assign fin_take = (state == WAIT) && io.alu_finished;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clock) begin
    if (reset || state != WAIT) tcnt <= '0;
    else                        tcnt <= tcnt + 1'b1;
  end

  assign tmo_take = (state == WAIT) && !io.alu_finished && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset)         err_q <= 1'b0;
    else if (fin_take) err_q <= 1'b0;
    else if (tmo_take) err_q <= 1'b1;
  end

  assign io.out_error = err_q;
`else
  assign tmo_take     = 1'b0;
  assign io.out_error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= {io.in_A, io.in_B};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      y_q <= '0;
      x_q <= '0;
    end else begin
      if (pop) {a_q, b_q} <= mem[rptr];
      if (fin_take) begin
        y_q <= io.alu_Y;
        x_q <= io.alu_X;
      end else if (tmo_take) begin
        y_q <= '1;
        x_q <= '1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (fin_take || tmo_take) state_nx = HOLD;
      HOLD:    if (io.out_ready) state_nx = empty ? IDLE : ISSUE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_o = 1'b0;
    valid_o = 1'b0;
    case (state)
      ISSUE:   start_o = 1'b1;
      HOLD:    valid_o = 1'b1;
      default: ;
    endcase
  end

  // in_ready is gated by reset so nothing is accepted while the block is being cleared.
  assign io.in_ready  = !full && !reset;
  assign io.count     = cnt;
  assign io.alu_start = start_o;
  assign io.alu_A     = a_q;
  assign io.alu_B     = b_q;
  assign io.out_valid = valid_o;
  assign io.out_Y     = y_q;
  assign io.out_X     = x_q;
endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: reference results are the product of each pushed
// pair (Y = high nibble, X = low nibble) from a behavioural ALU, checked in push order.
`timescale 1ns/1ps
module tb_alu_dispatch;
  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_dispatch_if #(.N(N), .DEPTH(DEPTH)) bus ();

  alu_dispatch #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    logic [N-1:0] y;
    logic [N-1:0] x;
    logic         err;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // behavioural ALU: multiplies the operands seen at alu_start, answers after alu_lat WAIT cycles
  logic         alu_en  = 1'b1;
  int           alu_lat = 2;
  logic         m_fin   = 1'b0;
  logic [N-1:0] m_y     = '0;
  logic [N-1:0] m_x     = '0;
  logic         spur    = 1'b0;
  logic         busy    = 1'b0;
  int           rem     = 0;
  logic [N-1:0] ma      = '0;
  logic [N-1:0] mb      = '0;

  assign bus.alu_finished = m_fin | spur;
  assign bus.alu_Y        = spur ? N'(10) : m_y;
  assign bus.alu_X        = spur ? N'(5)  : m_x;

  always @(negedge clock) begin
    logic [2*N-1:0] p;
    m_fin = 1'b0;
    if (reset) begin
      busy = 1'b0;
    end else if (busy) begin
      if (rem <= 1) begin
        p     = {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
        m_y   = p[2*N-1:N];
        m_x   = p[N-1:0];
        m_fin = 1'b1;
        busy  = 1'b0;
      end else begin
        rem--;
      end
    end else if (bus.alu_start && alu_en) begin
      busy = 1'b1;
      rem  = alu_lat;
      ma   = bus.alu_A;
      mb   = bus.alu_B;
    end
  end

  logic man_rdy  = 1'b0;
  logic rand_rdy = 1'b0;
  logic rnd_bit  = 1'b0;
  assign bus.out_ready = rand_rdy ? rnd_bit : man_rdy;

  always @(posedge clock) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // monitor: every accepted result is popped from the scoreboard and compared
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got Y=%0h X=%0h, required no output", bus.out_Y, bus.out_X);
      end else begin
        e = sbq.pop_front();
        check("out_Y", 32'(bus.out_Y), 32'(e.y));
        check("out_X", 32'(bus.out_X), 32'(e.x));
        check("out_error", 32'(bus.out_error), 32'(e.err));
      end
    end
  end

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic err);
    logic acc;
    exp_t e;
    int   prod;
    bus.in_valid = 1'b1;
    bus.in_A     = a;
    bus.in_B     = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock);
      #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        prod  = int'(a) * int'(b);
        e.y   = err ? '1 : N'(prod / (1 << N));
        e.x   = err ? '1 : N'(prod % (1 << N));
        e.err = err;
        sbq.push_back(e);
        return;
      end
    end
    bus.in_valid = 1'b0;
    check("push_accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_valid(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (bus.out_valid) return;
      @(posedge clock);
      #1;
    end
    check("wait_out_valid", 32'(bus.out_valid), 32'(1));
  endtask

  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim && sbq.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    check("scoreboard_drained", 32'(sbq.size()), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_A     = '0;
    bus.in_B     = '0;

    // reset held for two edges
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(0));
    check("rst_alu_start", 32'(bus.alu_start), 32'(0));
    check("rst_alu_A", 32'(bus.alu_A), 32'(0));
    check("rst_alu_B", 32'(bus.alu_B), 32'(0));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_Y", 32'(bus.out_Y), 32'(0));
    check("rst_out_X", 32'(bus.out_X), 32'(0));
    check("rst_out_error", 32'(bus.out_error), 32'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'(1));

    // single op, 3-cycle ALU, consumer initially stalled
    man_rdy = 1'b0;
    alu_lat = 3;
    push(4'd3, 4'd5, 1'b0);
    check("single_count_after_push", 32'(bus.count), 32'(1));
    check("single_no_start_yet", 32'(bus.alu_start), 32'(0));
    @(posedge clock);
    #1;
    check("single_alu_start", 32'(bus.alu_start), 32'(1));
    check("single_alu_A", 32'(bus.alu_A), 32'(3));
    check("single_alu_B", 32'(bus.alu_B), 32'(5));
    check("single_count_after_pop", 32'(bus.count), 32'(0));
    @(posedge clock);
    #1;
    check("single_start_one_cycle", 32'(bus.alu_start), 32'(0));
    check("single_operands_stable", 32'(bus.alu_A), 32'(3));
    repeat (2) @(posedge clock);
    #1;
    check("single_not_valid_early", 32'(bus.out_valid), 32'(0));
    @(posedge clock);
    #1;
    check("single_out_valid", 32'(bus.out_valid), 32'(1));
    check("single_out_Y", 32'(bus.out_Y), 32'(0));
    check("single_out_X", 32'(bus.out_X), 32'(15));
    repeat (3) @(posedge clock);
    #1;
    check("single_held_valid", 32'(bus.out_valid), 32'(1));
    check("single_held_X", 32'(bus.out_X), 32'(15));
    man_rdy = 1'b1;
    @(posedge clock);
    #1;
    check("single_released", 32'(bus.out_valid), 32'(0));
    man_rdy = 1'b0;

    // full FIFO: one result in HOLD, four queued, sixth push stalls
    alu_lat = 2;
    for (int i = 0; i < 5; i++) push(N'($urandom), N'($urandom), 1'b0);
    bus.in_A     = N'($urandom);
    bus.in_B     = N'($urandom);
    bus.in_valid = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("full_count", 32'(bus.count), 32'(DEPTH));
    check("full_in_ready", 32'(bus.in_ready), 32'(0));
    check("full_hold_valid", 32'(bus.out_valid), 32'(1));
    man_rdy = 1'b1;
    push(bus.in_A, bus.in_B, 1'b0);
    wait_drain(300);
    man_rdy = 1'b0;

    // simultaneous push and pop at count=2
    alu_lat = 1;
    push(N'($urandom), N'($urandom), 1'b0);
    wait_valid(20);
    push(N'($urandom), N'($urandom), 1'b0);
    push(N'($urandom), N'($urandom), 1'b0);
    check("pp_count_before", 32'(bus.count), 32'(2));
    man_rdy = 1'b1;
    push(N'($urandom), N'($urandom), 1'b0);
    check("pp_count_after", 32'(bus.count), 32'(2));
    wait_drain(300);
    man_rdy = 1'b0;

    // random stream across several pointer wraps, random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      alu_lat = int'($urandom_range(1, 4));
      push(N'($urandom), N'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
    wait_drain(1000);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // spurious finished in IDLE and in ISSUE
    spur = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    spur = 1'b0;
    check("spur_idle_no_valid", 32'(bus.out_valid), 32'(0));
    alu_lat = 4;
    push(4'd9, 4'd7, 1'b0);
    @(posedge clock);
    #1;
    check("spur_issue_cycle", 32'(bus.alu_start), 32'(1));
    spur = 1'b1;
    @(posedge clock);
    #1;
    spur = 1'b0;
    check("spur_issue_no_valid", 32'(bus.out_valid), 32'(0));
    wait_valid(20);
    man_rdy = 1'b1;
    wait_drain(50);
    man_rdy = 1'b0;

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // ALU never answers: watchdog result after TIMEOUT WAIT cycles
    alu_en = 1'b0;
    push(4'd2, 4'd3, 1'b1);
    repeat (TIMEOUT + 1) @(posedge clock);
    #1;
    check("tmo_not_yet", 32'(bus.out_valid), 32'(0));
    @(posedge clock);
    #1;
    check("tmo_out_valid", 32'(bus.out_valid), 32'(1));
    check("tmo_out_error", 32'(bus.out_error), 32'(1));
    check("tmo_out_Y", 32'(bus.out_Y), 32'(15));
    check("tmo_out_X", 32'(bus.out_X), 32'(15));
    man_rdy = 1'b1;
    @(posedge clock);
    #1;
    man_rdy = 1'b0;
    check("tmo_released", 32'(bus.out_valid), 32'(0));
`endif

    // reset while the ALU is busy and the FIFO holds a pair
    alu_en = 1'b0;
    push(4'd1, 4'd1, 1'b0);
    push(4'd4, 4'd4, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("midrst_waiting", 32'(bus.out_valid), 32'(0));
    check("midrst_count_before", 32'(bus.count), 32'(1));
    reset = 1'b1;
    @(posedge clock);
    #1;
    sbq.delete();
    check("midrst_count", 32'(bus.count), 32'(0));
    check("midrst_alu_start", 32'(bus.alu_start), 32'(0));
    check("midrst_alu_A", 32'(bus.alu_A), 32'(0));
    check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("midrst_in_ready", 32'(bus.in_ready), 32'(0));
    reset  = 1'b0;
    alu_en = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("midrst_fifo_discarded", 32'(bus.alu_start), 32'(0));
    check("midrst_idle_count", 32'(bus.count), 32'(0));

    // recovery after reset
    alu_lat = 2;
    man_rdy = 1'b1;
    push(4'd6, 4'd7, 1'b0);
    wait_drain(50);
    man_rdy = 1'b0;
    repeat (2) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
